// File: rtl/redmule_pkg.sv
// Shared RedMulE types: tiler regfile layout, tile descriptor, walker states.
// Holds the default array geometry and a constant-coefficient shift-add multiply.
package redmule_pkg;

  localparam int unsigned ARRAY_WIDTH_DEF  = 12;
  localparam int unsigned ARRAY_HEIGHT_DEF = 4;
  localparam int unsigned PIPE_REGS_DEF    = 3;
  localparam int unsigned BITW_DEF         = 16;
  localparam int unsigned TILE_N           = ARRAY_HEIGHT_DEF * (PIPE_REGS_DEF + 1);
  localparam int unsigned TILE_BYTES       = TILE_N * BITW_DEF / 8;

  // Regfile word indices as laid out by the tiler.
  localparam int unsigned NUM_REGS    = 10;
  localparam int unsigned X_ADDR      = 0;
  localparam int unsigned W_ADDR      = 1;
  localparam int unsigned Z_ADDR      = 2;
  localparam int unsigned X_ITERS     = 3;
  localparam int unsigned W_ITERS     = 4;
  localparam int unsigned LEFTOVERS   = 5;
  localparam int unsigned X_D1_STRIDE = 6;
  localparam int unsigned X_ROWS_OFFS = 7;
  localparam int unsigned W_D0_STRIDE = 8;
  localparam int unsigned Z_D0_STRIDE = 9;

  typedef struct packed {
    logic [NUM_REGS-1:0][31:0] hwpe_params;
  } ctrl_regfile_t;

  typedef struct packed {
    logic [15:0] mr;
    logic [15:0] kc;
    logic [15:0] nc;
    logic [7:0]  rows;
    logic [7:0]  cols_n;
    logic [7:0]  cols_k;
    logic [31:0] x_addr;
    logic [31:0] w_addr;
    logic [31:0] z_addr;
    logic        last_n;
    logic        last_tile;
  } tile_desc_t;

  typedef enum logic [1:0] {
    WALK_IDLE = 2'd0,
    WALK_RUN  = 2'd1,
    WALK_DONE = 2'd2
  } walk_state_e;

  // v * c built from shifted adds; c is an elaboration-time constant.
  function automatic logic [31:0] mul_const(input logic [31:0] v, input int unsigned c);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (c[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/redmule_tile_addr_acc.sv
// One loop dimension: index counter plus two running address offsets.
// Wraps to zero after the last index and flags the wrap to the next outer dimension.
module redmule_tile_addr_acc (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [15:0] iters_i,
  input  logic [31:0] inc_a_i,
  input  logic [31:0] inc_b_i,
  output logic [15:0] cnt_o,
  output logic [31:0] ptr_a_o,
  output logic [31:0] ptr_b_o,
  output logic        last_o,
  output logic        wrap_o
);

  logic [15:0] cnt_q;
  logic [31:0] ptr_a_q, ptr_b_q;

  assign last_o  = (cnt_q == iters_i - 16'd1);
  assign wrap_o  = step_i & last_o;
  assign cnt_o   = cnt_q;
  assign ptr_a_o = ptr_a_q;
  assign ptr_b_o = ptr_b_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      ptr_a_q <= '0;
      ptr_b_q <= '0;
    end else if (clear_i || start_i || wrap_o) begin
      cnt_q   <= '0;
      ptr_a_q <= '0;
      ptr_b_q <= '0;
    end else if (step_i) begin
      cnt_q   <= cnt_q + 16'd1;
      ptr_a_q <= ptr_a_q + inc_a_i;
      ptr_b_q <= ptr_b_q + inc_b_i;
    end
  end

endmodule

// File: rtl/redmule_tile_walker.sv
// Walks the tiler's mr/kc/nc iteration space and emits one descriptor per tile (valid/ready).
// Optional handshake stall counter under REDMULE_TILE_WALKER_PERF_EN.
module redmule_tile_walker
  import redmule_pkg::*;
#(
  parameter int unsigned ARRAY_WIDTH  = ARRAY_WIDTH_DEF,
  parameter int unsigned ARRAY_HEIGHT = ARRAY_HEIGHT_DEF,
  parameter int unsigned PIPE_REGS    = PIPE_REGS_DEF,
  parameter int unsigned BITW         = BITW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          cfg_valid_i,
  input  ctrl_regfile_t reg_file_i,
  output logic          desc_valid_o,
  input  logic          desc_ready_i,
  output tile_desc_t    desc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   stall_cnt_o
);

  localparam int unsigned TN = ARRAY_HEIGHT * (PIPE_REGS + 1);
  localparam int unsigned TB = TN * BITW / 8;

  walk_state_e state_q;
  logic        cfg_valid_q, valid_q, done_q;
  logic [15:0] x_rows_iter_q, x_cols_iter_q, w_cols_iter_q;
  logic [7:0]  x_rows_lft_q, x_cols_lft_q, w_cols_lft_q;
  logic [31:0] x_base_q, w_base_q, z_base_q, x_d1_stride_q;
  logic [31:0] x_mr_inc_q, w_nc_inc_q, z_mr_inc_q;

  logic        start, hs, zero_iters;
  logic [15:0] nc_cnt, kc_cnt, mr_cnt;
  logic [31:0] nc_x, nc_w, kc_w, kc_z, mr_x, mr_z;
  logic        nc_last, kc_last, mr_last, nc_wrap, kc_wrap, mr_wrap;
  logic        last_tile;
  tile_desc_t  desc;

  assign start = cfg_valid_i & ~cfg_valid_q & (state_q == WALK_IDLE);
  assign hs    = valid_q & desc_ready_i;
  assign zero_iters = (reg_file_i.hwpe_params[X_ITERS][31:16] == 16'd0) ||
                      (reg_file_i.hwpe_params[X_ITERS][15:0]  == 16'd0) ||
                      (reg_file_i.hwpe_params[W_ITERS][15:0]  == 16'd0);

  // Edge detector tracks the tiler valid even through clear so a held level never restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cfg_valid_q <= 1'b0;
    else         cfg_valid_q <= cfg_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= WALK_IDLE;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_cols_iter_q <= '0;
      x_rows_lft_q  <= '0; x_cols_lft_q  <= '0; w_cols_lft_q  <= '0;
      x_base_q      <= '0; w_base_q      <= '0; z_base_q      <= '0;
      x_d1_stride_q <= '0;
      x_mr_inc_q    <= '0; w_nc_inc_q    <= '0; z_mr_inc_q    <= '0;
    end else if (clear_i) begin
      state_q       <= WALK_IDLE;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_cols_iter_q <= '0;
      x_rows_lft_q  <= '0; x_cols_lft_q  <= '0; w_cols_lft_q  <= '0;
      x_base_q      <= '0; w_base_q      <= '0; z_base_q      <= '0;
      x_d1_stride_q <= '0;
      x_mr_inc_q    <= '0; w_nc_inc_q    <= '0; z_mr_inc_q    <= '0;
    end else begin
      case (state_q)
        WALK_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_rows_iter_q <= reg_file_i.hwpe_params[X_ITERS][31:16];
            x_cols_iter_q <= reg_file_i.hwpe_params[X_ITERS][15:0];
            w_cols_iter_q <= reg_file_i.hwpe_params[W_ITERS][15:0];
            x_rows_lft_q  <= reg_file_i.hwpe_params[LEFTOVERS][31:24];
            x_cols_lft_q  <= reg_file_i.hwpe_params[LEFTOVERS][23:16];
            w_cols_lft_q  <= reg_file_i.hwpe_params[LEFTOVERS][7:0];
            x_base_q      <= reg_file_i.hwpe_params[X_ADDR];
            w_base_q      <= reg_file_i.hwpe_params[W_ADDR];
            z_base_q      <= reg_file_i.hwpe_params[Z_ADDR];
            x_d1_stride_q <= reg_file_i.hwpe_params[X_D1_STRIDE];
            x_mr_inc_q    <= reg_file_i.hwpe_params[X_ROWS_OFFS];
            w_nc_inc_q    <= mul_const(reg_file_i.hwpe_params[W_D0_STRIDE], TN);
            z_mr_inc_q    <= mul_const(reg_file_i.hwpe_params[Z_D0_STRIDE], ARRAY_WIDTH);
            if (zero_iters) begin
              state_q <= WALK_DONE;
            end else begin
              state_q <= WALK_RUN;
              valid_q <= 1'b1;
            end
          end
        end
        WALK_RUN: begin
          if (hs && last_tile) begin
            state_q <= WALK_DONE;
            valid_q <= 1'b0;
          end
        end
        WALK_DONE: begin
          state_q <= WALK_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= WALK_IDLE;
      endcase
    end
  end

  // nc innermost: steps on every handshake; each wrap carries outward.
  redmule_tile_addr_acc i_nc_acc (
    .clk_i, .rst_ni, .clear_i, .start_i(start), .step_i(hs),
    .iters_i(x_cols_iter_q), .inc_a_i(32'(TB)), .inc_b_i(w_nc_inc_q),
    .cnt_o(nc_cnt), .ptr_a_o(nc_x), .ptr_b_o(nc_w), .last_o(nc_last), .wrap_o(nc_wrap)
  );

  redmule_tile_addr_acc i_kc_acc (
    .clk_i, .rst_ni, .clear_i, .start_i(start), .step_i(nc_wrap),
    .iters_i(w_cols_iter_q), .inc_a_i(32'(TB)), .inc_b_i(32'(TB)),
    .cnt_o(kc_cnt), .ptr_a_o(kc_w), .ptr_b_o(kc_z), .last_o(kc_last), .wrap_o(kc_wrap)
  );

  redmule_tile_addr_acc i_mr_acc (
    .clk_i, .rst_ni, .clear_i, .start_i(start), .step_i(kc_wrap),
    .iters_i(x_rows_iter_q), .inc_a_i(x_mr_inc_q), .inc_b_i(z_mr_inc_q),
    .cnt_o(mr_cnt), .ptr_a_o(mr_x), .ptr_b_o(mr_z), .last_o(mr_last), .wrap_o(mr_wrap)
  );

  assign last_tile = nc_last & kc_last & mr_last;

  always_comb begin
    desc           = '0;
    desc.mr        = mr_cnt;
    desc.kc        = kc_cnt;
    desc.nc        = nc_cnt;
    desc.rows      = (mr_last && x_rows_lft_q != 8'd0) ? x_rows_lft_q : 8'(ARRAY_WIDTH);
    desc.cols_n    = (nc_last && x_cols_lft_q != 8'd0) ? x_cols_lft_q : 8'(TN);
    desc.cols_k    = (kc_last && w_cols_lft_q != 8'd0) ? w_cols_lft_q : 8'(TN);
    desc.x_addr    = x_base_q + mr_x + nc_x;
    desc.w_addr    = w_base_q + nc_w + kc_w;
    desc.z_addr    = z_base_q + mr_z + kc_z;
    desc.last_n    = nc_last;
    desc.last_tile = last_tile;
  end

  // Counters only move on handshakes, so the gated descriptor is stable under backpressure.
  assign desc_o       = valid_q ? desc : '0;
  assign desc_valid_o = valid_q;
  assign busy_o       = (state_q == WALK_RUN);
  assign done_o       = done_q;

`ifdef REDMULE_TILE_WALKER_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        stall_q <= '0;
    else if (clear_i || start)                          stall_q <= '0;
    else if (valid_q && !desc_ready_i && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{x_d1_stride_q, mr_wrap,
                         reg_file_i.hwpe_params[W_ITERS][31:16],
                         reg_file_i.hwpe_params[LEFTOVERS][15:8]};

endmodule

// File: tb/tb_redmule_tile_walker.sv
// Randomized bench for redmule_tile_walker against a nested-loop descriptor model.
`timescale 1ns/1ps
module tb_redmule_tile_walker;
  import redmule_pkg::*;

  localparam int AW = 12;
  localparam int TN = 16;
  localparam int TB = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          desc_ready_i = 1'b0;
  ctrl_regfile_t reg_file_i = '0;
  logic          desc_valid_o, busy_o, done_o;
  tile_desc_t    desc_o;
  logic [31:0]   stall_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  tile_desc_t exp_q[$];

  always #5 clk_i = ~clk_i;

  redmule_tile_walker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .cfg_valid_i(cfg_valid_i),
    .reg_file_i(reg_file_i), .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .desc_o(desc_o), .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  function automatic ctrl_regfile_t mk_rf(input int xr, input int xc, input int wc,
                                          input int lr, input int lc, input int lw,
                                          input logic [31:0] xro, input logic [31:0] wd0,
                                          input logic [31:0] zd0, input logic [31:0] xb,
                                          input logic [31:0] wb, input logic [31:0] zb);
    ctrl_regfile_t rf;
    rf = '0;
    rf.hwpe_params[X_ITERS]     = {16'(xr), 16'(xc)};
    rf.hwpe_params[W_ITERS]     = {16'hA5A5, 16'(wc)};
    rf.hwpe_params[LEFTOVERS]   = {8'(lr), 8'(lc), 8'h5A, 8'(lw)};
    rf.hwpe_params[X_D1_STRIDE] = 32'h0000_DEAD;
    rf.hwpe_params[X_ROWS_OFFS] = xro;
    rf.hwpe_params[W_D0_STRIDE] = wd0;
    rf.hwpe_params[Z_D0_STRIDE] = zd0;
    rf.hwpe_params[X_ADDR]      = xb;
    rf.hwpe_params[W_ADDR]      = wb;
    rf.hwpe_params[Z_ADDR]      = zb;
    return rf;
  endfunction

  // Reference: enumerate tiles in mr/kc/nc order with plain multiplications.
  task automatic build_exp(input ctrl_regfile_t rf);
    int xr, xc, wc;
    logic [7:0] lr, lc, lw;
    tile_desc_t d;
    exp_q.delete();
    xr = int'(rf.hwpe_params[X_ITERS][31:16]);
    xc = int'(rf.hwpe_params[X_ITERS][15:0]);
    wc = int'(rf.hwpe_params[W_ITERS][15:0]);
    lr = rf.hwpe_params[LEFTOVERS][31:24];
    lc = rf.hwpe_params[LEFTOVERS][23:16];
    lw = rf.hwpe_params[LEFTOVERS][7:0];
    for (int mr = 0; mr < xr; mr++)
      for (int kc = 0; kc < wc; kc++)
        for (int nc = 0; nc < xc; nc++) begin
          d.mr        = 16'(mr);
          d.kc        = 16'(kc);
          d.nc        = 16'(nc);
          d.rows      = (mr == xr-1 && lr != 0) ? lr : 8'(AW);
          d.cols_n    = (nc == xc-1 && lc != 0) ? lc : 8'(TN);
          d.cols_k    = (kc == wc-1 && lw != 0) ? lw : 8'(TN);
          d.x_addr    = rf.hwpe_params[X_ADDR] + 32'(mr) * rf.hwpe_params[X_ROWS_OFFS] + 32'(nc*TB);
          d.w_addr    = rf.hwpe_params[W_ADDR] + 32'(nc*TN) * rf.hwpe_params[W_D0_STRIDE] + 32'(kc*TB);
          d.z_addr    = rf.hwpe_params[Z_ADDR] + 32'(mr*AW) * rf.hwpe_params[Z_D0_STRIDE] + 32'(kc*TB);
          d.last_n    = (nc == xc-1);
          d.last_tile = (nc == xc-1) && (kc == wc-1) && (mr == xr-1);
          exp_q.push_back(d);
        end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({desc_valid_o, busy_o, done_o, stall_cnt_o, desc_o} !== '0)
      $display("FAIL reset_outputs: got vld=%0b busy=%0b done=%0b stall=%0d desc=%h, want all zero",
               desc_valid_o, busy_o, done_o, stall_cnt_o, desc_o);
    else n_pass++;
    @(posedge clk_i); #1 rst_ni = 1'b1;
  endtask

  // Full walk under random backpressure, optionally re-pulsing cfg_valid_i mid-walk.
  task automatic test_walk(input string name, input ctrl_regfile_t rf, input int rdy_pct,
                           input int repulse_at, input ctrl_regfile_t rf2);
    int stalls, cyc, dones;
    bit held_vld, fin;
    tile_desc_t held, e;
    logic [31:0] exp_stall;
    build_exp(rf);
    stalls = 0; cyc = 0; dones = 0; held_vld = 0; fin = 0; held = '0;
    @(posedge clk_i); #1;
    reg_file_i = rf; cfg_valid_i = 1'b1;
    desc_ready_i = ($urandom_range(99) < rdy_pct);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    reg_file_i  = {NUM_REGS{$urandom()}};
    while (!fin && cyc < 2000) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        n_checks++;
        if ({desc_valid_o, busy_o} !== 2'b11)
          $display("FAIL %s first_valid: got vld=%0b busy=%0b, want 1 1", name, desc_valid_o, busy_o);
        else n_pass++;
      end
      if (held_vld) begin
        n_checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== held)
          $display("FAIL %s stall_stable: got vld=%0b desc=%h, want vld=1 desc=%h", name, desc_valid_o, desc_o, held);
        else n_pass++;
      end
      held_vld = 0;
      if (desc_valid_o === 1'b1) begin
        if (desc_ready_i) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL %s extra_desc: got desc=%h, want no descriptor", name, desc_o);
          end else begin
            e = exp_q.pop_front();
            if (desc_o !== e) $display("FAIL %s desc: got %h, want %h", name, desc_o, e);
            else n_pass++;
          end
        end else begin
          stalls++;
          held = desc_o;
          held_vld = 1;
        end
      end
      if (done_o === 1'b1) begin dones++; fin = 1; end
      @(posedge clk_i); #1;
      cyc++;
      desc_ready_i = ($urandom_range(99) < rdy_pct);
      if (cyc == repulse_at) begin cfg_valid_i = 1'b1; reg_file_i = rf2; end
      else cfg_valid_i = 1'b0;
    end
    desc_ready_i = 1'b0;
    n_checks++;
    if (!fin) $display("FAIL %s done_timeout: got no done_o within %0d cycles, want one pulse", name, cyc);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s desc_count: got %0d descriptors missing, want 0", name, exp_q.size());
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if ({done_o, busy_o, desc_valid_o} !== 3'b000)
      $display("FAIL %s after_done: got done=%0b busy=%0b vld=%0b, want 0 0 0", name, done_o, busy_o, desc_valid_o);
    else n_pass++;
`ifdef REDMULE_TILE_WALKER_PERF_EN
    exp_stall = 32'(stalls);
`else
    exp_stall = 32'd0;
`endif
    n_checks++;
    if (stall_cnt_o !== exp_stall) $display("FAIL %s stall_cnt: got %0d, want %0d", name, stall_cnt_o, exp_stall);
    else n_pass++;
  endtask

  task automatic test_zero_iters();
    int first, dones;
    bit saw_vld, saw_busy;
    first = -1; dones = 0; saw_vld = 0; saw_busy = 0;
    @(posedge clk_i); #1;
    reg_file_i = mk_rf(2, 0, 3, 0, 0, 0, 32'd64, 32'd64, 32'd64, 32'h100, 32'h200, 32'h300);
    cfg_valid_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_i); #1;
      cfg_valid_i = 1'b0;
      if (desc_valid_o) saw_vld = 1;
      if (busy_o) saw_busy = 1;
      if (done_o) begin dones++; if (first < 0) first = c; end
    end
    n_checks++;
    if (saw_vld || saw_busy) $display("FAIL zero_iters_vld: got vld=%0b busy=%0b, want 0 0", saw_vld, saw_busy);
    else n_pass++;
    n_checks++;
    if (first != 2 || dones != 1) $display("FAIL zero_iters_done: got done at cycle %0d count %0d, want cycle 2 count 1", first, dones);
    else n_pass++;
  endtask

  task automatic test_clear(input ctrl_regfile_t rf);
    bit saw;
    saw = 0;
    @(posedge clk_i); #1;
    reg_file_i = rf; cfg_valid_i = 1'b1; desc_ready_i = 1'b1;
    @(posedge clk_i); #1 cfg_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; desc_ready_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({desc_valid_o, busy_o, stall_cnt_o} !== '0)
      $display("FAIL clear_drop: got vld=%0b busy=%0b stall=%0d, want 0 0 0", desc_valid_o, busy_o, stall_cnt_o);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (done_o || desc_valid_o) saw = 1;
    end
    n_checks++;
    if (saw) $display("FAIL clear_no_done: got done/valid activity after clear, want none");
    else n_pass++;
  endtask

  initial begin
    ctrl_regfile_t rf_a, rf_b, rf_c, rf_r;
    rf_a = mk_rf(2, 1, 2, 0, 0, 0, 32'd384, 32'd64, 32'd64, 32'h1000, 32'h2000, 32'h3000);
    rf_b = mk_rf(2, 2, 1, 1, 4, 0, 32'd40, 32'd32, 32'd32, 32'h8000, 32'h9000, 32'hA000);
    rf_c = mk_rf(3, 3, 3, 5, 7, 9, 32'd11, 32'd13, 32'd17, 32'h40, 32'h80, 32'hC0);
    test_reset();
    test_walk("m24n16k32", rf_a, 100, -1, rf_a);
    test_walk("leftovers", rf_b, 100, -1, rf_b);
    test_walk("backpressure", rf_a, 30, -1, rf_a);
    test_zero_iters();
    test_clear(rf_a);
    test_walk("restart", rf_a, 100, -1, rf_a);
    test_walk("cfg_repulse", rf_a, 60, 2, rf_c);
    for (int i = 0; i < 4; i++) begin
      rf_r = mk_rf($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(0, 11), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
      test_walk("random", rf_r, $urandom_range(40, 100), -1, rf_r);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/redmule_tile_walker.md
Name: redmule_tile_walker

Overview:
Consumes the re-encoded RedMulE register file produced by the tiler and walks the tile iteration space. For each tile it emits one descriptor: tile indices, effective (leftover-aware) tile sizes, X/W/Z byte addresses and last flags. Descriptors go out over a valid/ready handshake to the streamer/scheduler side. The block is the decoding and consuming end of the tiler's regfile encoding.

Parameters:
ARRAY_WIDTH, 12, rows per M-tile (X rows / Z rows)
ARRAY_HEIGHT, 4, PE rows; TILE_N = ARRAY_HEIGHT*(PIPE_REGS+1)
PIPE_REGS, 3, FMA pipeline registers
BITW, 16, element width in bits; TILE_BYTES = TILE_N*BITW/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear, returns to IDLE
cfg_valid_i  in  1  tiler valid; config sampled on rising edge of this signal while IDLE
reg_file_i  in  ctrl_regfile_t  tiler-encoded regfile (X_ITERS, W_ITERS, LEFTOVERS, X_D1_STRIDE, X_ROWS_OFFS, W_D0_STRIDE, Z_D0_STRIDE, X_ADDR, W_ADDR, Z_ADDR)
desc_valid_o  out  1  descriptor valid
desc_ready_i  in  1  descriptor accepted
desc_o  out  tile_desc_t  {mr, kc, nc [15:0]; rows, cols_n, cols_k [7:0]; x_addr, w_addr, z_addr [31:0]; last_n, last_tile}
busy_o  out  1  walk in progress
done_o  out  1  one-cycle pulse after last descriptor accepted
stall_cnt_o  out  32  handshake stall counter (see Optional Feature)

Behaviour:
- Reset and clear values: state IDLE; all outputs 0; all internal pointers and counters 0.
- Decode at sample:
  - x_rows_iter = X_ITERS[31:16]; x_cols_iter = X_ITERS[15:0]; w_cols_iter = W_ITERS[15:0].
  - Leftovers: x_rows_lftovr = LEFTOVERS[31:24]; x_cols_lftovr = [23:16]; w_cols_lftovr = [7:0].
  - Strides and base addresses are taken from their regfile words. All are registered locally, so reg_file_i may change afterwards.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on cfg_valid_i rising edge when all three iteration counts are nonzero.
  - IDLE -> DONE if any iteration count is zero; no descriptor is emitted.
  - RUN -> DONE when the last_tile descriptor handshakes.
  - DONE -> IDLE unconditionally; done_o=1 for exactly that cycle.
- Loop order: nc innermost, then kc, then mr outermost.
  - nc counts 0..x_cols_iter-1; kc counts 0..w_cols_iter-1; mr counts 0..x_rows_iter-1.
  - Counters advance only on desc_valid_o & desc_ready_i.
- First descriptor: desc_valid_o rises in the cycle after the sample (latency 1). It stays high throughout RUN. Back-to-back descriptors are issued every cycle while ready=1.
- Stability: while valid & !ready, desc_o is held bit-stable.
- Effective tile sizes:
  - rows = x_rows_lftovr if (mr == last && x_rows_lftovr != 0), else ARRAY_WIDTH.
  - cols_n uses the same rule with nc / x_cols_lftovr / TILE_N.
  - cols_k uses the same rule with kc / w_cols_lftovr / TILE_N.
- Address generation uses running pointers with adders only, no multipliers. All sums are 32-bit and wrap modulo 2^32.
  - x_addr = X_ADDR + mr*X_ROWS_OFFS + nc*TILE_BYTES.
  - w_addr = W_ADDR + nc*TILE_N*W_D0_STRIDE + kc*TILE_BYTES.
  - z_addr = Z_ADDR + mr*ARRAY_WIDTH*Z_D0_STRIDE + kc*TILE_BYTES.
  - X_D1_STRIDE is recorded for downstream use only.
- Flags: last_n = (nc == x_cols_iter-1). last_tile = last_n & last kc & last mr.
- Ignored events: cfg_valid_i while RUN or DONE is ignored.
- clear_i priority: clear_i wins over a handshake in the same cycle. A mid-walk clear drops desc_valid_o on the next cycle with no done_o.
- busy_o = (state == RUN).

Optional Feature:
REDMULE_TILE_WALKER_PERF_EN:
- Defined: stall_cnt_o counts cycles with desc_valid_o & !desc_ready_i. It is 32-bit saturating, zeroed on each accepted start and on clear_i, and held after DONE.
- Undefined: stall_cnt_o is tied to 0 and the counter logic is absent.

Decomposition:
- tile_desc_t and the TILE_N / TILE_BYTES localparams go in redmule_pkg, next to the existing regfile index constants.
- One natural sub-module: redmule_tile_addr_acc, a per-dimension counter plus running-pointer adder with a wrap/last flag. It is instantiated three times (nc, kc, mr).

Test Plan:
- m=24, n=16, k=32 (X_ITERS=0x0002_0001, W_ITERS=..._0002, no leftovers); X_ROWS_OFFS=384, W_D0_STRIDE=64, Z_D0_STRIDE=64; bases 0x1000 / 0x2000 / 0x3000 -> exactly 4 descriptors in this order:
  - (0,0,0): x=0x1000, w=0x2000, z=0x3000
  - (0,1,0): z=0x3020
  - (1,0,0): x=0x1180, z=0x3300
  - (1,1,0): z=0x3320, last_tile=1
  - then done_o pulses once.
- m=13, n=20, k=16 (x_rows_lftovr=1, x_cols_lftovr=4) -> 4 descriptors; mr=1 tiles have rows=1; nc=1 tiles have cols_n=4 and last_n=1; cols_k=16 throughout.
- desc_ready_i random 30% during the first scenario -> desc_o stable during every stall; same 4 descriptors in order; with PERF_EN, stall_cnt_o equals the counted stall cycles.
- X_ITERS with x_cols_iter=0 -> no desc_valid_o; done_o pulses exactly 2 cycles after the start edge.
- clear_i asserted after the 2nd handshake -> desc_valid_o=0 next cycle, busy_o=0, no done_o; a new start restarts from (0,0,0).
- cfg_valid_i re-pulsed mid-walk with different sizes -> ignored; the walk completes with the original config.
